// File: rtl/node_net_iface.sv
// node_net_iface: mesh router local-port interface with a credit-controlled inject queue
// and an eject queue that returns one credit per flit consumed by the host.
module node_net_iface #(
    parameter int FLIT_W    = 20,
    parameter int CREDITS   = 4,
    parameter int TXQ_DEPTH = 4,
    parameter int EJQ_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [3:0]        position,
    input  logic [3:0]        tx_dest,
    input  logic [FLIT_W-9:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_out_valid,
    input  logic              credit_in,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              credit_out,
    output logic [FLIT_W-9:0] rx_data,
    output logic [3:0]        rx_src,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic              err_credit,
    output logic              err_overflow,
    output logic              err_misroute
);
    localparam int TP_W = $clog2(TXQ_DEPTH);
    localparam int TC_W = $clog2(TXQ_DEPTH + 1);
    localparam int EP_W = EJQ_DEPTH > 1 ? $clog2(EJQ_DEPTH) : 1;
    localparam int EC_W = $clog2(EJQ_DEPTH + 1);
    localparam int EJ_W = FLIT_W - 4;
    localparam logic [3:0] CR_MAX = 4'(CREDITS);

    logic [FLIT_W-1:0] tx_mem [TXQ_DEPTH];
    logic [TP_W-1:0]   tx_wr, tx_rd;
    logic [TC_W-1:0]   tx_cnt;
    logic [3:0]        credits;
    logic              send, push;

    logic [EJ_W-1:0]   ej_mem [EJQ_DEPTH];
    logic [EP_W-1:0]   ej_wr, ej_rd;
    logic [EC_W-1:0]   ej_cnt;
    logic              pop, accept;

    assign send     = (tx_cnt != '0) && (credits != '0);
    assign tx_ready = (tx_cnt != TC_W'(TXQ_DEPTH)) || send;
    assign push     = tx_valid && tx_ready;

    always_ff @(posedge clk)
        if (push) tx_mem[tx_wr] <= {tx_dest, position, tx_data};

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            tx_wr          <= '0;
            tx_rd          <= '0;
            tx_cnt         <= '0;
            credits        <= CR_MAX;
            flit_out       <= '0;
            flit_out_valid <= 1'b0;
            tx_count       <= '0;
            err_credit     <= 1'b0;
        end else begin
            tx_wr          <= tx_wr + TP_W'(push);
            tx_rd          <= tx_rd + TP_W'(send);
            tx_cnt         <= tx_cnt + TC_W'(push) - TC_W'(send);
            flit_out       <= send ? tx_mem[tx_rd] : '0;
            flit_out_valid <= send;
            tx_count       <= tx_count + CNT_W'(send);
            // a returned credit and a send in the same cycle cancel out
            if (credit_in && !send) begin
                if (credits == CR_MAX) err_credit <= 1'b1;
                else credits <= credits + 4'd1;
            end else if (send && !credit_in) begin
                credits <= credits - 4'd1;
            end
        end
    end

    assign rx_valid        = ej_cnt != '0;
    assign pop             = rx_valid && rx_ready;
    assign accept          = flit_in_valid && ((ej_cnt != EC_W'(EJQ_DEPTH)) || pop);
    assign {rx_src, rx_data} = ej_mem[ej_rd];

    // only src and payload are kept; dest is consumed by the misroute check
    always_ff @(posedge clk)
        if (accept) ej_mem[ej_wr] <= flit_in[EJ_W-1:0];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ej_wr        <= '0;
            ej_rd        <= '0;
            ej_cnt       <= '0;
            credit_out   <= 1'b0;
            rx_count     <= '0;
            err_overflow <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            if (accept) ej_wr <= (ej_wr == EP_W'(EJQ_DEPTH - 1)) ? '0 : ej_wr + 1'b1;
            if (pop) ej_rd <= (ej_rd == EP_W'(EJQ_DEPTH - 1)) ? '0 : ej_rd + 1'b1;
            ej_cnt     <= ej_cnt + EC_W'(accept) - EC_W'(pop);
            credit_out <= pop;
            rx_count   <= rx_count + CNT_W'(accept);
            if (flit_in_valid && !accept) err_overflow <= 1'b1;
            if (accept && flit_in[FLIT_W-1:FLIT_W-4] != position) err_misroute <= 1'b1;
        end
    end
endmodule

// File: tb/tb_node_net_iface.sv
// tb_node_net_iface: directed scenarios plus random traffic against a queue-level reference model.
module tb_node_net_iface;
    localparam int CREDITS = 4;
    localparam int TXQ     = 4;
    localparam int EJQ     = 4;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  position = 4'd5;
    logic [3:0]  tx_dest = '0;
    logic [11:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [19:0] flit_out;
    logic        flit_out_valid;
    logic        credit_in = 1'b0;
    logic [19:0] flit_in = '0;
    logic        flit_in_valid = 1'b0;
    logic        credit_out;
    logic [11:0] rx_data;
    logic [3:0]  rx_src;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] tx_count, rx_count;
    logic        err_credit, err_overflow, err_misroute;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    node_net_iface dut (
        .clk(clk), .RST(RST), .position(position), .tx_dest(tx_dest), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .flit_out(flit_out),
        .flit_out_valid(flit_out_valid), .credit_in(credit_in), .flit_in(flit_in),
        .flit_in_valid(flit_in_valid), .credit_out(credit_out), .rx_data(rx_data),
        .rx_src(rx_src), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_count(tx_count),
        .rx_count(rx_count), .err_credit(err_credit), .err_overflow(err_overflow),
        .err_misroute(err_misroute)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: packet queues and a credit integer
    logic [19:0] m_txq[$];
    logic [15:0] m_ejq[$];
    int          m_cred;
    logic        m_fov, m_co, m_ec, m_eo, m_em;
    logic [19:0] m_fo;
    logic [15:0] m_txc, m_rxc;

    task automatic model_reset();
        m_txq.delete();
        m_ejq.delete();
        m_cred = CREDITS;
        {m_fov, m_co, m_ec, m_eo, m_em} = '0;
        m_fo  = '0;
        m_txc = '0;
        m_rxc = '0;
    endtask

    task automatic model_edge();
        bit snd, acc, pp;
        snd = m_txq.size() > 0 && m_cred > 0;
        acc = tx_valid && (m_txq.size() < TXQ || snd);
        m_fov = snd;
        m_fo  = '0;
        if (snd) begin
            m_fo = m_txq.pop_front();
            m_txc++;
        end
        if (acc) m_txq.push_back({tx_dest, position, tx_data});
        m_cred = m_cred + int'(credit_in) - int'(snd);
        if (m_cred > CREDITS) begin
            m_cred = CREDITS;
            m_ec = 1'b1;
        end
        pp = m_ejq.size() > 0 && rx_ready;
        m_co = pp;
        if (pp) void'(m_ejq.pop_front());
        if (flit_in_valid) begin
            if (m_ejq.size() < EJQ) begin
                m_ejq.push_back(flit_in[15:0]);
                m_rxc++;
                if (flit_in[19:16] != position) m_em = 1'b1;
            end else m_eo = 1'b1;
        end
    endtask

    task automatic check_all();
        check("flit_out_valid", flit_out_valid, m_fov);
        check("flit_out", flit_out, m_fo);
        check("tx_ready", tx_ready, m_txq.size() < TXQ || (m_txq.size() > 0 && m_cred > 0));
        check("tx_count", tx_count, m_txc);
        check("rx_count", rx_count, m_rxc);
        check("credit_out", credit_out, m_co);
        check("rx_valid", rx_valid, m_ejq.size() != 0);
        check("err_credit", err_credit, m_ec);
        check("err_overflow", err_overflow, m_eo);
        check("err_misroute", err_misroute, m_em);
        if (m_ejq.size() != 0) begin
            check("rx_src", rx_src, m_ejq[0][15:12]);
            check("rx_data", rx_data, m_ejq[0][11:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        tx_valid = 1'b0;
        credit_in = 1'b0;
        flit_in_valid = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 RST = 1'b1;
        #1 check_all();
    endtask

    task automatic push_n(input int n, output int pushed, output int snt);
        pushed = 0;
        snt = 0;
        for (int i = 0; i < 4 * n + 4 && pushed < n; i++) begin
            tx_valid = 1'b1;
            tx_dest  = 4'(i);
            tx_data  = 12'(i);
            pushed  += int'(tx_ready);
            cyc();
            snt += int'(flit_out_valid);
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        int pushed, sent, s2, r_out;
        do_reset();
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_flit_out", flit_out, 20'h0);

        // single packet: send one cycle after the push
        position = 4'd5;
        tx_dest  = 4'd9;
        tx_data  = 12'h123;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        check("first_send_early", flit_out_valid, 1'b0);
        cyc();
        check("first_flit", flit_out, 20'h95123);
        check("first_valid", flit_out_valid, 1'b1);
        check("first_tx_count", tx_count, 16'd1);
        cyc();
        check("first_one_cycle", flit_out_valid, 1'b0);

        // credit stall
        do_reset();
        push_n(6, pushed, sent);
        check("stall_pushed", pushed, 6);
        repeat (10) begin
            cyc();
            sent += int'(flit_out_valid);
        end
        check("stall_sent", sent, 4);
        push_n(2, pushed, s2);
        check("stall_full_ready", tx_ready, 1'b0);
        sent += s2;
        credit_in = 1'b1;
        repeat (2) begin
            cyc();
            sent += int'(flit_out_valid);
        end
        credit_in = 1'b0;
        repeat (6) begin
            cyc();
            sent += int'(flit_out_valid);
        end
        check("stall_after_credit", sent, 6);
        check("stall_tx_count", tx_count, 16'd6);

        // credit return coinciding with a send, then one extra credit
        do_reset();
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        check("simul_sent", flit_out_valid, 1'b1);
        check("simul_no_err", err_credit, 1'b0);
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        check("extra_err_credit", err_credit, 1'b1);
        push_n(5, pushed, sent);
        repeat (6) begin
            cyc();
            sent += int'(flit_out_valid);
        end
        check("extra_cred_stays4", sent, 4);

        // eject and credit return
        do_reset();
        position = 4'd5;
        flit_in = 20'h53ABC;
        flit_in_valid = 1'b1;
        cyc();
        flit_in_valid = 1'b0;
        check("ej_valid", rx_valid, 1'b1);
        check("ej_src", rx_src, 4'd3);
        check("ej_data", rx_data, 12'hABC);
        check("ej_rx_count", rx_count, 16'd1);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        check("ej_credit_pulse", credit_out, 1'b1);
        cyc();
        check("ej_credit_once", credit_out, 1'b0);

        // overflow, then pop+push at full, misrouted
        do_reset();
        for (int i = 0; i < 5; i++) begin
            flit_in = {4'd5, 4'(i), 12'(i)};
            flit_in_valid = 1'b1;
            cyc();
        end
        check("ovf_rx_count", rx_count, 16'd4);
        check("ovf_flag", err_overflow, 1'b1);
        check("ovf_no_misroute", err_misroute, 1'b0);
        flit_in = 20'h7E0F0;
        rx_ready = 1'b1;
        cyc();
        idle_inputs();
        check("misroute_flag", err_misroute, 1'b1);
        check("full_pop_accept", rx_count, 16'd5);
        check("full_pop_head", rx_data, 12'd1);

        // random traffic with a router that only returns credits it owes
        do_reset();
        position = 4'($urandom);
        r_out = 0;
        for (int c = 0; c < 3000; c++) begin
            tx_valid      = 1'($urandom);
            tx_dest       = 4'($urandom);
            tx_data       = 12'($urandom);
            credit_in     = r_out > 0 && ($urandom_range(2) != 0);
            flit_in_valid = $urandom_range(2) == 0;
            flit_in       = {($urandom_range(7) == 0) ? 4'($urandom) : position, 16'($urandom)};
            rx_ready      = $urandom_range(3) != 0;
            cyc();
            r_out = r_out - int'(credit_in) + int'(m_fov);
        end

        // asynchronous reset mid-burst
        tx_valid = 1'b1;
        flit_in_valid = 1'b1;
        rx_ready = 1'b1;
        credit_in = 1'b1;
        repeat (3) cyc();
        #2 RST = 1'b0;
        model_reset();
        #1 check_all();
        check("async_fov", flit_out_valid, 1'b0);
        check("async_credit_out", credit_out, 1'b0);
        check("async_tx_ready", tx_ready, 1'b1);
        idle_inputs();
        @(posedge clk);
        #3 RST = 1'b1;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
